// File: rtl/space_inv_pkg.sv
// Shared definitions for the space-invaders playfield: screen geometry,
// colour constants, the projectile record and the slot-index width helper.
package space_inv_pkg;

    // Visible screen extent
    localparam int X_MAX = 639;
    localparam int Y_MAX = 479;

    // Playfield borders inside the visible area
    localparam int BORDER_LEFT   = 16;
    localparam int BORDER_RIGHT  = 623;
    localparam int BORDER_TOP    = 36;
    localparam int BORDER_BOTTOM = 463;

    // 12-bit RGB colours used by the renderer
    localparam logic [11:0] COLOUR_BLACK  = 12'h000;
    localparam logic [11:0] COLOUR_WHITE  = 12'hFFF;
    localparam logic [11:0] COLOUR_GREEN  = 12'h0F0;
    localparam logic [11:0] COLOUR_RED    = 12'hF00;
    localparam logic [11:0] COLOUR_SHOT   = 12'hFF0;
    localparam logic [11:0] COLOUR_BORDER = 12'h888;

    // One projectile: occupancy flag plus top-left corner
    typedef struct packed {
        logic       active;
        logic [9:0] x;
        logic [9:0] y;
    } shot_t;

    // Width of a slot index; never narrower than one bit
    function automatic int slot_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shot_slot.sv
// One projectile register set: launch, upward motion, retirement at the top
// border or on an alien hit, and a registered hit-box compare against the scan.
// Pause qualification is done by the parent; tick/launch/retire arrive pre-gated.
module shot_slot
    import space_inv_pkg::*;
#(
    parameter int SHOT_W        = 2,
    parameter int SHOT_H        = 8,
    parameter int SHOT_VELOCITY = 4,
    parameter int Y_TOP         = BORDER_TOP
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       launch,
    input  logic       retire,
    input  logic [9:0] launch_x,
    input  logic [9:0] launch_y,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    output shot_t      state,
    output logic       pix_hit,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y
);

    // A shot whose top is below this line can still move; otherwise it would
    // cross Y_TOP (or underflow) and is retired instead.
    localparam logic [10:0] RETIRE_BELOW = 11'(Y_TOP + SHOT_VELOCITY);
    localparam logic [9:0]  STEP         = 10'(SHOT_VELOCITY);
    localparam logic [10:0] W_EXT        = 11'(SHOT_W);
    localparam logic [10:0] H_EXT        = 11'(SHOT_H);

    logic in_x;
    logic in_y;

    assign in_x = (pixel_x >= state.x) && ({1'b0, pixel_x} < ({1'b0, state.x} + W_EXT));
    assign in_y = (pixel_y >= state.y) && ({1'b0, pixel_y} < ({1'b0, state.y} + H_EXT));

    // Projectile state: a hit beats everything, a fresh launch does not move
    // on its own tick, and an active shot steps up or retires on each tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= '0;
        end else if (retire && state.active) begin
            state.active <= 1'b0;
        end else if (launch) begin
            state <= '{active: 1'b1, x: launch_x, y: launch_y};
        end else if (tick && state.active) begin
            if ({1'b0, state.y} < RETIRE_BELOW) begin
                state.active <= 1'b0;
            end else begin
                state.y <= state.y - STEP;
            end
        end
    end

    // Registered hit-box compare with a snapshot of the position it used, so
    // the reported x/y always belong to the same cycle as the hit flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_hit <= 1'b0;
            pix_x   <= '0;
            pix_y   <= '0;
        end else begin
            pix_hit <= state.active && in_x && in_y;
            pix_x   <= state.x;
            pix_y   <= state.y;
        end
    end

endmodule

// File: rtl/shot_pool.sv
// Pool of NUM_SHOTS concurrent player projectiles with a fire cooldown.
// Contains the free-slot priority encoder, cooldown counter, fire qualifier
// and the pixel priority mux; each projectile lives in a shot_slot instance.
// Optional build macro SHOT_EDGE_FIRE_EN: fire qualifies only from a latched
// rising edge instead of auto-repeating while held.
module shot_pool
    import space_inv_pkg::*;
#(
    parameter int NUM_SHOTS       = 4,
    parameter int SHOT_W          = 2,
    parameter int SHOT_H          = 8,
    parameter int SHOT_VELOCITY   = 4,
    parameter int COOLDOWN_FRAMES = 12,
    parameter int Y_TOP           = BORDER_TOP,
    localparam int SW             = slot_width(NUM_SHOTS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pause,
    input  logic                 frame_tick,
    input  logic                 fire,
    input  logic [9:0]           orig_x,
    input  logic [9:0]           orig_y,
    input  logic [9:0]           pixel_x,
    input  logic [9:0]           pixel_y,
    input  logic                 hit_valid,
    input  logic [SW-1:0]        hit_slot,
    output logic [NUM_SHOTS-1:0] active_mask,
    output logic                 fire_ack,
    output logic                 shot_pixel,
    output logic [SW-1:0]        shot_slot,
    output logic [9:0]           shot_x,
    output logic [9:0]           shot_y
);

    localparam int            CW      = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_FRAMES);

    logic                 tick_run;
    logic                 fire_qual;
    logic                 launch;
    logic                 any_free;
    logic [NUM_SHOTS-1:0] free_onehot;
    logic [NUM_SHOTS-1:0] launch_vec;
    logic [NUM_SHOTS-1:0] retire_vec;
    logic [NUM_SHOTS-1:0] slot_active;
    logic [NUM_SHOTS-1:0] pix_hits;
    logic [CW-1:0]        cooldown;
    logic [9:0]           spawn_x;
    logic [9:0]           spawn_y;

    shot_t      slot_state [NUM_SHOTS];
    logic [9:0] pix_xs     [NUM_SHOTS];
    logic [9:0] pix_ys     [NUM_SHOTS];

    logic          sel_found;
    logic [SW-1:0] sel_idx;
    logic [9:0]    sel_x;
    logic [9:0]    sel_y;
    logic [SW-1:0] last_slot;
    logic [9:0]    last_x;
    logic [9:0]    last_y;

    assign tick_run    = frame_tick & ~pause;
    assign spawn_x     = orig_x - 10'(SHOT_W / 2);
    assign spawn_y     = orig_y - 10'(SHOT_H);
    assign active_mask = slot_active;

    // Lowest free slot, taken from occupancy at the start of the cycle so a
    // slot retired by a same-cycle hit cannot be relaunched until later.
    always_comb begin
        free_onehot = '0;
        any_free    = 1'b0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            if (!slot_active[i] && !any_free) begin
                free_onehot[i] = 1'b1;
                any_free       = 1'b1;
            end
        end
    end

`ifdef SHOT_EDGE_FIRE_EN
    logic fire_d;
    logic fire_latch;
    logic fire_rise;

    assign fire_rise = fire & ~fire_d;
    assign fire_qual = fire_latch | fire_rise;

    // Rising-edge latch held between ticks; fire_d keeps sampling during pause
    // so a press made while paused is not replayed as an edge afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fire_d     <= 1'b0;
            fire_latch <= 1'b0;
        end else begin
            fire_d <= fire;
            if (pause || launch || !any_free) begin
                fire_latch <= 1'b0;
            end else if (fire_rise) begin
                fire_latch <= 1'b1;
            end
        end
    end
`else
    assign fire_qual = fire;
`endif

    assign launch = tick_run && fire_qual && (cooldown == '0) && any_free;

    // Steer launch and hit strobes to their slots; out-of-range hits vanish.
    always_comb begin
        launch_vec = '0;
        retire_vec = '0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            launch_vec[i] = launch && free_onehot[i];
            retire_vec[i] = hit_valid && !pause && (int'(hit_slot) == i);
        end
    end

    // Cooldown reloads on every launch and otherwise counts frames down to 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cooldown <= '0;
        end else if (launch) begin
            cooldown <= CD_LOAD;
        end else if (tick_run && (cooldown != '0)) begin
            cooldown <= cooldown - CW'(1);
        end
    end

    // One-cycle acknowledge aligned with the slot load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fire_ack <= 1'b0;
        end else begin
            fire_ack <= launch;
        end
    end

    for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_slot
        shot_slot #(
            .SHOT_W        (SHOT_W),
            .SHOT_H        (SHOT_H),
            .SHOT_VELOCITY (SHOT_VELOCITY),
            .Y_TOP         (Y_TOP)
        ) u_slot (
            .clk      (clk),
            .reset_n  (reset_n),
            .tick     (tick_run),
            .launch   (launch_vec[g]),
            .retire   (retire_vec[g]),
            .launch_x (spawn_x),
            .launch_y (spawn_y),
            .pixel_x  (pixel_x),
            .pixel_y  (pixel_y),
            .state    (slot_state[g]),
            .pix_hit  (pix_hits[g]),
            .pix_x    (pix_xs[g]),
            .pix_y    (pix_ys[g])
        );
        assign slot_active[g] = slot_state[g].active;
    end

    // Pixel priority mux over the registered per-slot hits: lowest index wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_x     = '0;
        sel_y     = '0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            if (pix_hits[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = SW'(i);
                sel_x     = pix_xs[i];
                sel_y     = pix_ys[i];
            end
        end
    end

    // Remember the last owning slot so the outputs hold between shot pixels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_slot <= '0;
            last_x    <= '0;
            last_y    <= '0;
        end else if (sel_found) begin
            last_slot <= sel_idx;
            last_x    <= sel_x;
            last_y    <= sel_y;
        end
    end

    assign shot_pixel = sel_found;
    assign shot_slot  = sel_found ? sel_idx : last_slot;
    assign shot_x     = sel_found ? sel_x   : last_x;
    assign shot_y     = sel_found ? sel_y   : last_y;

endmodule

// File: tb/tb_shot_pool.sv
// Self-checking bench for shot_pool: a behavioural model predicts each cycle's
// outputs, pushes them to a scoreboard queue, and they are popped and compared
// one cycle later when the DUT has produced its registered response.
module tb_shot_pool;

    localparam int NS = 4;
    localparam int W  = 2;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int CD = 12;
    localparam int YT = 36;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pause;
    logic       frame_tick;
    logic       fire;
    logic [9:0] orig_x;
    logic [9:0] orig_y;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       hit_valid;
    logic [1:0] hit_slot;
    logic [3:0] active_mask;
    logic       fire_ack;
    logic       shot_pixel;
    logic [1:0] shot_slot;
    logic [9:0] shot_x;
    logic [9:0] shot_y;

    typedef struct {
        logic       ack;
        logic [3:0] mask;
        logic       pix;
        logic [1:0] slot;
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    exp_t sb[$];

    int checks    = 0;
    int errors    = 0;
    int ack_count = 0;

    bit m_act [NS];
    int m_x   [NS];
    int m_y   [NS];
    int m_cd;
    int m_last_slot;
    int m_last_x;
    int m_last_y;
    bit m_prev_fire;
    bit m_latch;

    shot_pool #(
        .NUM_SHOTS       (NS),
        .SHOT_W          (W),
        .SHOT_H          (H),
        .SHOT_VELOCITY   (V),
        .COOLDOWN_FRAMES (CD),
        .Y_TOP           (YT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pause       (pause),
        .frame_tick  (frame_tick),
        .fire        (fire),
        .orig_x      (orig_x),
        .orig_y      (orig_y),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .hit_valid   (hit_valid),
        .hit_slot    (hit_slot),
        .active_mask (active_mask),
        .fire_ack    (fire_ack),
        .shot_pixel  (shot_pixel),
        .shot_slot   (shot_slot),
        .shot_x      (shot_x),
        .shot_y      (shot_y)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [3:0] modelMask();
        logic [3:0] m;
        m = '0;
        for (int i = 0; i < NS; i++) m[i] = m_act[i];
        return m;
    endfunction

    // Drive one cycle of inputs, predict the response, wait one edge, compare.
    task automatic applyStimulus(input bit tick, input bit fire_i, input bit hv, input int hs,
                                 input int px, input int py, input bit pause_i);
        exp_t e;
        int   found;
        int   free_i;
        bit   run;
        bit   rise;
        bit   qual;
        bit   launch;

        frame_tick = tick;
        fire       = fire_i;
        hit_valid  = hv;
        hit_slot   = 2'(hs);
        pixel_x    = 10'(px);
        pixel_y    = 10'(py);
        pause      = pause_i;

        found = -1;
        for (int i = 0; i < NS; i++) begin
            if (found < 0 && m_act[i] && px >= m_x[i] && px < m_x[i] + W &&
                py >= m_y[i] && py < m_y[i] + H) found = i;
        end
        if (found >= 0) begin
            m_last_slot = found;
            m_last_x    = m_x[found];
            m_last_y    = m_y[found];
        end
        e.pix  = (found >= 0);
        e.slot = 2'(m_last_slot);
        e.x    = 10'(m_last_x);
        e.y    = 10'(m_last_y);

        free_i = -1;
        for (int i = 0; i < NS; i++) if (free_i < 0 && !m_act[i]) free_i = i;

        run  = !pause_i;
        rise = fire_i && !m_prev_fire;
`ifdef SHOT_EDGE_FIRE_EN
        qual = m_latch || rise;
`else
        qual = fire_i;
`endif
        launch = tick && run && qual && (m_cd == 0) && (free_i >= 0);

        for (int i = 0; i < NS; i++) begin
            if (run && hv && hs == i && m_act[i]) begin
                m_act[i] = 1'b0;
            end else if (launch && i == free_i) begin
                m_act[i] = 1'b1;
                m_x[i]   = (int'(orig_x) - W / 2) & 1023;
                m_y[i]   = (int'(orig_y) - H) & 1023;
            end else if (run && tick && m_act[i]) begin
                if (m_y[i] < YT + V) m_act[i] = 1'b0;
                else                 m_y[i] -= V;
            end
        end

        if (launch)                        m_cd = CD;
        else if (run && tick && m_cd > 0)  m_cd--;

        if (!run || launch || free_i < 0) m_latch = 1'b0;
        else if (rise)                    m_latch = 1'b1;
        m_prev_fire = fire_i;

        e.ack  = launch;
        e.mask = modelMask();
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        checkOutput("fire_ack",    fire_ack,    e.ack);
        checkOutput("active_mask", active_mask, e.mask);
        checkOutput("shot_pixel",  shot_pixel,  e.pix);
        checkOutput("shot_slot",   shot_slot,   e.slot);
        checkOutput("shot_x",      shot_x,      e.x);
        checkOutput("shot_y",      shot_y,      e.y);
        if (fire_ack) ack_count++;
    endtask

    // n frames of 10 cycles: nine scan cycles then one frame_tick cycle.
    task automatic runFrames(input int n, input bit fire_i, input bit pause_i);
        for (int f = 0; f < n; f++) begin
            for (int c = 0; c < 9; c++) begin
                applyStimulus(0, fire_i, 0, 0, int'($urandom_range(316, 324)),
                              int'($urandom_range(30, 430)), pause_i);
            end
            applyStimulus(1, fire_i, 0, 0, int'($urandom_range(316, 324)),
                          int'($urandom_range(30, 430)), pause_i);
        end
    endtask

    initial begin
        logic [3:0] saved_mask;
        int         start_acks;

        reset_n    = 1'b0;
        pause      = 1'b0;
        frame_tick = 1'b0;
        fire       = 1'b0;
        hit_valid  = 1'b0;
        hit_slot   = '0;
        orig_x     = 10'd320;
        orig_y     = 10'd420;
        pixel_x    = '0;
        pixel_y    = '0;
        for (int i = 0; i < NS; i++) begin
            m_act[i] = 1'b0;
            m_x[i]   = 0;
            m_y[i]   = 0;
        end
        m_cd        = 0;
        m_last_slot = 0;
        m_last_x    = 0;
        m_last_y    = 0;
        m_prev_fire = 1'b0;
        m_latch     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_mask",  active_mask, 0);
        checkOutput("reset_ack",   fire_ack,    0);
        checkOutput("reset_pixel", shot_pixel,  0);
        checkOutput("reset_slot",  shot_slot,   0);
        checkOutput("reset_x",     shot_x,      0);
        checkOutput("reset_y",     shot_y,      0);
        reset_n = 1'b1;

        $display("[TB] launch and motion");
        runFrames(1, 1, 0);
        applyStimulus(0, 1, 0, 0, 319, 412, 0);
        checkOutput("slot0_launch_x", shot_x, 319);
        checkOutput("slot0_launch_y", shot_y, 412);
        runFrames(3, 1, 0);
        applyStimulus(0, 1, 0, 0, 320, 405, 0);
        checkOutput("scan_320_405_pix",  shot_pixel, 1);
        checkOutput("scan_320_405_slot", shot_slot,  0);
        checkOutput("slot0_moved_y",     shot_y,     400);
        applyStimulus(0, 1, 0, 0, 321, 405, 0);
        checkOutput("scan_321_405_pix", shot_pixel, 0);

        runFrames(51, 1, 0);
`ifndef SHOT_EDGE_FIRE_EN
        checkOutput("autorepeat_launches", ack_count,   4);
        checkOutput("pool_full_mask",      active_mask, 4'b1111);
`endif

        $display("[TB] hits");
        applyStimulus(0, 0, 1, 2, 0, 0, 0);
        applyStimulus(1, 1, 1, 1, 0, 0, 0);
`ifndef SHOT_EDGE_FIRE_EN
        checkOutput("hit_tick_mask", active_mask, 4'b1101);
        checkOutput("hit_tick_ack",  fire_ack,    1);
`endif
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 2, 0, 0, 0);
        applyStimulus(0, 0, 1, 3, 0, 0, 0);
        checkOutput("all_hit_mask", active_mask, 0);
        runFrames(13, 0, 0);

        $display("[TB] top border retirement");
        orig_y = 10'd48;
        runFrames(1, 1, 0);
        applyStimulus(0, 0, 0, 0, 319, 40, 0);
        checkOutput("near_top_pix", shot_pixel, 1);
        checkOutput("near_top_y",   shot_y,     40);
        runFrames(1, 0, 0);
        applyStimulus(0, 0, 0, 0, 320, 36, 0);
        checkOutput("at_top_pix",  shot_pixel,  1);
        checkOutput("at_top_y",    shot_y,      36);
        checkOutput("at_top_mask", active_mask, 4'b0001);
        runFrames(1, 0, 0);
        checkOutput("retired_mask", active_mask, 0);
        applyStimulus(0, 0, 0, 0, 320, 38, 0);
        checkOutput("retired_pix", shot_pixel, 0);

        $display("[TB] pause");
        orig_y = 10'd420;
        runFrames(20, 1, 0);
        saved_mask = modelMask();
        runFrames(2, 1, 1);
        applyStimulus(0, 1, 1, 0, 0, 0, 1);
        if (m_act[0]) begin
            applyStimulus(0, 1, 0, 0, m_x[0], m_y[0] + 3, 1);
            checkOutput("paused_scan_pix", shot_pixel, 1);
        end
        runFrames(3, 1, 1);
        checkOutput("paused_mask", active_mask, saved_mask);
        runFrames(2, 1, 0);

`ifdef SHOT_EDGE_FIRE_EN
        $display("[TB] edge-qualified fire");
        for (int i = 0; i < NS; i++) applyStimulus(0, 0, 1, i, 0, 0, 0);
        runFrames(13, 0, 0);
        start_acks = ack_count;
        runFrames(100, 1, 0);
        checkOutput("edge_hold_launches", ack_count - start_acks, 1);
        start_acks = ack_count;
        runFrames(1, 0, 0);
        runFrames(1, 1, 0);
        runFrames(1, 0, 0);
        runFrames(14, 1, 0);
        checkOutput("edge_toggle_launches", ack_count - start_acks, 2);
`else
        start_acks = ack_count;
        for (int i = 0; i < NS; i++) applyStimulus(0, 0, 1, i, 0, 0, 0);
        runFrames(13, 0, 0);
        runFrames(14, 1, 0);
        checkOutput("repeat_after_clear", ack_count - start_acks, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
